mem_responder: RTL and testbench

Memory-side responder for the multicycle core's memory port. Accepts one read or write request at a time from the datapath (address, write data, read/write strobes, instruction/data bank select). Services it against two internal word arrays (instruction bank, data bank) after a programmable number of wait states, then returns a one-cycle `ready` pulse with the read word or an error flag. Replaces the fixed-latency memory wrapper, so the control unit can be made latency-tolerant.

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multicycle memory responder with programmable wait states
//
// Services one read or write at a time against two internal word arrays
// (instruction bank, data bank). Each access takes WAIT_CYCLES wait states,
// and each request ends with a one-cycle ready pulse.
//
// Parameters
//   ADDR_W       word-index bits per bank (2^ADDR_W 32-bit words per bank)
//   WAIT_CYCLES  wait states before each access, 0..7
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   add          byte address
//   write_data   store data
//   write/read   request strobes, sampled only in IDLE
//   i_ou_d       bank select: 0 = instruction bank, 1 = data bank
//   out          last completed read word (registered)
//   ready        one-cycle response pulse (registered)
//   err          request rejected, valid with ready (registered)
//   busy         high whenever the FSM is not idle (registered)
//   dbg_addr     debug word index into the data bank
//   dbg_data     combinational data-bank word at dbg_addr
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       add,
  input  logic [31:0]       write_data,
  input  logic              write,
  input  logic              read,
  input  logic              i_ou_d,
  output logic [31:0]       out,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              bank_q;
  logic              wr_q;
  logic              bad_q;

  logic [31:0] out_q;
  logic        ready_q, err_q, busy_q;

  logic [31:0] ibank [0:(1<<ADDR_W)-1];
  logic [31:0] dbank [0:(1<<ADDR_W)-1];

  // Both strobes high still counts as a request so it can be answered with err.
  logic req, bad, do_access;
  assign req = read | write;
  assign bad = (read & write) | (add[1:0] != 2'b00) | (|add[31:ADDR_W+2]);
  assign do_access = (state_q == S_ACCESS) && !bad_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Rejected requests take the zero-wait path so their response
          // slot lands one cycle after capture; ACCESS then skips the arrays.
          if (bad || (WAIT_CYCLES == 0)) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      bank_q  <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q  <= add[ADDR_W+1:2];
        wdata_q <= write_data;
        bank_q  <= i_ou_d;
        wr_q    <= write;
        bad_q   <= bad;
      end
      if (do_access && !wr_q) begin
        out_q <= bank_q ? dbank[addr_q] : ibank[addr_q];
      end
      // Outputs follow the next state so they are plain flops.
      ready_q <= (state_d == S_RESP);
      err_q   <= (state_d == S_RESP) && bad_q;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Arrays have no reset; a write is dropped if reset lands on its ACCESS edge.
  always_ff @(posedge clk) begin
    if (rst_n && do_access && wr_q) begin
      if (bank_q) dbank[addr_q] <= wdata_q;
      else        ibank[addr_q] <= wdata_q;
    end
  end

  assign out      = out_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign dbg_data = dbank[dbg_addr];

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk;
  logic [31:0] add;
  logic [31:0] write_data;
  logic        i_ou_d;
  logic [9:0]  dbg_addr;

  logic        rst_n_w [3];
  logic        rd      [3];
  logic        wr      [3];
  logic [31:0] out_w   [3];
  logic        ready_w [3];
  logic        err_w   [3];
  logic        busy_w  [3];
  logic [31:0] dbg_w   [3];

  int tests_run = 0;
  int tests_failed = 0;

  // Instance 0: WAIT_CYCLES=3, instance 1: WAIT_CYCLES=1, instance 2: WAIT_CYCLES=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(10),
      .WAIT_CYCLES((g == 0) ? 3 : ((g == 1) ? 1 : 0))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_w[g]),
      .add       (add),
      .write_data(write_data),
      .write     (wr[g]),
      .read      (rd[g]),
      .i_ou_d    (i_ou_d),
      .out       (out_w[g]),
      .ready     (ready_w[g]),
      .err       (err_w[g]),
      .busy      (busy_w[g]),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at #1 after an edge with DUT d idle. Holds strobes until ready.
  task automatic do_req(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd, input logic b,
                        input bit stray, input int exp_lat, input logic exp_err,
                        input string tag);
    int lat;
    add = a; write_data = wd; i_ou_d = b; rd[d] = r; wr[d] = w;
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(busy_w[d]), 32'd1);
    if (stray) begin
      add = a + 32'd4; write_data = ~wd;
    end
    lat = 0;
    while (!ready_w[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (stray) wr[d] = ~wr[d];
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(err_w[d]), 32'(exp_err));
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_1cyc"}, 32'(ready_w[d]), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rst_n_w[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
    end
    add = '0; write_data = '0; i_ou_d = 1'b0; dbg_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 32'(ready_w[i]), 32'd0);
      check("rst_err",   32'(err_w[i]),   32'd0);
      check("rst_busy",  32'(busy_w[i]),  32'd0);
      check("rst_out",   out_w[i],        32'd0);
      rst_n_w[i] = 1'b1;
    end
    @(posedge clk); #1;

    // Write then read, WAIT_CYCLES=1
    do_req(1, 0, 1, 32'h0C, 32'h12345678, 1, 0, 2, 0, "wr0c");
    do_req(1, 1, 0, 32'h0C, 32'h0, 1, 0, 2, 0, "rd0c");
    check("rd0c_out", out_w[1], 32'h12345678);
    dbg_addr = 10'd3; #1;
    check("dbg3", dbg_w[1], 32'h12345678);

    // Bank isolation
    do_req(1, 0, 1, 32'h0, 32'hAAAA0001, 0, 0, 2, 0, "wr_i0");
    do_req(1, 0, 1, 32'h0, 32'h5555FFFF, 1, 0, 2, 0, "wr_d0");
    do_req(1, 1, 0, 32'h0, 32'h0, 0, 0, 2, 0, "rd_i0");
    check("rd_i0_out", out_w[1], 32'hAAAA0001);
    do_req(1, 1, 0, 32'h0, 32'h0, 1, 0, 2, 0, "rd_d0");
    check("rd_d0_out", out_w[1], 32'h5555FFFF);

    // Errors
    do_req(1, 1, 0, 32'h6, 32'h0, 1, 0, 1, 1, "err_misalign");
    check("err_misalign_out", out_w[1], 32'h5555FFFF);
    do_req(1, 1, 0, 32'h1000, 32'h0, 1, 0, 1, 1, "err_range");
    do_req(1, 1, 1, 32'h0C, 32'hFFFFFFFF, 1, 0, 1, 1, "err_both");
    dbg_addr = 10'd3; #1;
    check("err_both_nowrite", dbg_w[1], 32'h12345678);

    // Ignored strobes on WAIT_CYCLES=3
    do_req(0, 0, 1, 32'h24, 32'h99999999, 1, 0, 4, 0, "pre_stray");
    do_req(0, 0, 1, 32'h20, 32'h0BADF00D, 1, 1, 4, 0, "stray");
    dbg_addr = 10'd8; #1;
    check("stray_target", dbg_w[0], 32'h0BADF00D);
    dbg_addr = 10'd9; #1;
    check("stray_other", dbg_w[0], 32'h99999999);

    // Reset mid-WAIT on WAIT_CYCLES=3
    do_req(0, 0, 1, 32'h10, 32'h11111111, 1, 0, 4, 0, "pre_rst");
    add = 32'h10; write_data = 32'hDEADBEEF; i_ou_d = 1'b1; wr[0] = 1'b1;
    @(posedge clk); #1;            // captured, first WAIT cycle
    @(posedge clk); #1;            // second WAIT cycle
    rst_n_w[0] = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy",  32'(busy_w[0]),  32'd0);
    check("midrst_ready", 32'(ready_w[0]), 32'd0);
    rst_n_w[0] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready_w[0]) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    dbg_addr = 10'd4; #1;
    check("midrst_mem", dbg_w[0], 32'h11111111);

    // WAIT_CYCLES=0 throughput
    do_req(2, 0, 1, 32'h4, 32'hCAFE0004, 1, 0, 1, 0, "thr_pre");
    add = 32'h4; i_ou_d = 1'b1; rd[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("thr_ready", 32'(ready_w[2]), 32'((k % 3) == 1));
      check("thr_busy",  32'(busy_w[2]),  32'((k % 3) != 2));
    end
    rd[2] = 1'b0;
    check("thr_out", out_w[2], 32'hCAFE0004);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
